alu_ctrl_seq: RTL and testbench
===============================

// Module: alu_ctrl_seq
// PURPOSE
//  Successor ALU control for the MIPS core. Decodes opcode/funct to the ALU fncode, as today.
//  Adds an iterative HI/LO multiply-divide sequencer (MULT/MULTU/DIV/DIVU, MFHI/MFLO/MTHI/MTLO).
//  Drives a stall to the pipeline while a HI/LO access collides with a running operation.
//  Sits between the decode stage and the execute stage.
// PARAMETERS
//  WIDTH  32  operand/HI/LO width; WIDTH >= 2; iteration counter is $clog2(WIDTH)+1 bits
// PORTS
//  clk           in   1      rising-edge clock
//  reset         in   1      asynchronous, active-high reset
//  valid_in      in   1      decoded instruction present this cycle
//  opcode        in   6      instruction opcode
//  rtype_fncode  in   6      R-type funct field
//  op_a          in   WIDTH  rs value (multiplicand / dividend / MTHI-MTLO source)
//  op_b          in   WIDTH  rt value (multiplier / divisor)
//  fncode        out  6      ALU function code (combinational)
//  stall         out  1      hold the pipeline; instruction is not consumed
//  busy          out  1      sequencer running
//  hi, lo        out  WIDTH  HI/LO registers
// BEHAVIOUR
//  Decode is combinational and independent of valid_in:
//   ADDIU->ADDU, SLTI->SLT, SLTIU->SLTU, ANDI->AND, ORI->OR, XORI->XOR, RTYPE->rtype_fncode.
//   Any other opcode gives 6'h3F.
//  HI/LO class = RTYPE with funct 0x10-0x13 or 0x18-0x1B.
//  stall = valid_in & busy & HI/LO class (combinational). All other instructions never stall.
//  Reset (any time, including mid-operation): state=IDLE, busy=0, hi=lo=0, counter=0.
//   The partial result is discarded.
//  FSM states: IDLE, MUL, DIV, FIX.
//   IDLE: on valid_in & ~stall:
//    MULT/MULTU -> MUL; DIV/DIVU -> DIV; load operands, counter=WIDTH, busy=1 next cycle.
//    MTHI: hi<=op_a next edge. MTLO: lo<=op_a next edge. No state change.
//   MUL: shift-add, 1 bit per cycle, over WIDTH cycles.
//   DIV: restoring division, 1 quotient bit per cycle, over WIDTH cycles.
//   At counter 0: unsigned ops write {hi,lo} and go to IDLE; signed ops go to FIX.
//   FIX: 1 cycle. Apply sign correction, write hi/lo, go to IDLE.
//  Latency from start edge to hi/lo valid and busy low:
//   Unsigned ops: WIDTH+1 cycles. Signed ops: WIDTH+2 cycles.
//  Results:
//   MULT(U): {hi,lo} = full 2*WIDTH product.
//   DIV(U): lo = quotient, hi = remainder. Signed remainder takes the sign of the dividend.
//  Divide by zero: lo = {WIDTH{1'b1}}, hi = op_a. Signed ops use the same values; no FIX correction.
//  Signed overflow (DIV of INT_MIN by -1): lo = INT_MIN, hi = 0.
//  hi/lo hold their value while busy; MFHI/MFLO read them only when busy=0 (else stall).
//  Start instructions arriving while busy are stalled, never queued or dropped.
//  An HI/LO-class instruction in the cycle busy falls is not stalled.
//   It sees the final hi/lo, which are already written on that edge.
// CONFIGURATION
//  ALU_CTRL_SIGNED_MULDIV_EN defined:
//   MULT and DIV run signed with the FIX state, as above.
//  ALU_CTRL_SIGNED_MULDIV_EN undefined:
//   FIX state is absent. MULT/DIV decode like any other R-type funct (fncode passthrough).
//   They do not start the sequencer. MULTU/DIVU are unaffected.
// TESTING
//  MULTU 0xFFFFFFFF*0xFFFFFFFF -> after 33 cycles: hi=0xFFFFFFFE, lo=0x00000001, busy 1 for 32 cycles.
//  DIV -7/2 (SIGNED_EN) -> 34 cycles: lo=0xFFFFFFFD, hi=0xFFFFFFFF.
//   Also DIV 0x80000000/-1 -> lo=0x80000000, hi=0.
//  DIVU 5/0 -> lo=0xFFFFFFFF, hi=5.
//   Also MFLO issued at start+3 -> stall=1 until busy falls, then 0.
//  Assert reset at start+10 of MULTU -> busy=0, hi=lo=0 immediately.
//   A new MULTU 3*4 then gives lo=12.
//  Decode sweep: opcodes 0x09,0x0A,0x0B,0x0C,0x0D,0x0E,0x00 map per table; 0x23 -> 0x3F.
//   ADDIU with busy=1 -> stall=0.
//  MTHI 0xA5A5A5A5 in IDLE -> hi updated next edge.
//   Same MTHI while busy -> stall=1, hi unchanged until busy falls.

Source files
------------

// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq: MIPS ALU control decode plus an iterative HI/LO multiply/divide sequencer.
//   Decode (combinational): opcode/rtype_fncode -> fncode; non-listed opcodes give 6'h3F.
//   Sequencer: MULTU/DIVU always, MULT/DIV only when ALU_CTRL_SIGNED_MULDIV_EN is defined;
//   MTHI/MTLO write hi/lo directly; MFHI/MFLO and starts stall while busy.
// Ports:
//   clk, reset (async, active-high)
//   valid_in, opcode[5:0], rtype_fncode[5:0], op_a/op_b[WIDTH-1:0]  - decoded instruction
//   fncode[5:0]  - ALU function code
//   stall        - hold pipeline (HI/LO-class instruction while busy)
//   busy         - sequencer running
//   hi, lo       - HI/LO registers
module alu_ctrl_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  input  logic [5:0]       opcode,
  input  logic [5:0]       rtype_fncode,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [5:0]       fncode,
  output logic             stall,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH) + 1;
`ifdef ALU_CTRL_SIGNED_MULDIV_EN
  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;
  localparam bit SGN = 1'b1;
`else
  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;
  localparam bit SGN = 1'b0;
`endif
  state_t               state_q;
  logic [CW-1:0]        cnt_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [WIDTH-1:0]     opnd_q, hi_q, lo_q;
  logic                 rtype, hilo, go, is_mul, is_div, sgn_op, sa, sb, dz, ge;
  logic [WIDTH-1:0]     ma, mb, rnew;
  logic [WIDTH:0]       msum, rsh;
  logic [2*WIDTH-1:0]   step_d;
`ifdef ALU_CTRL_SIGNED_MULDIV_EN
  logic                 sgn_q, div_q, qneg_q, rneg_q;
  logic [2*WIDTH-1:0]   fin_d;
`endif
  assign rtype  = opcode == 6'h00;
  assign fncode = opcode == 6'h09 ? 6'h21 :
                  opcode == 6'h0A ? 6'h2A :
                  opcode == 6'h0B ? 6'h2B :
                  opcode == 6'h0C ? 6'h24 :
                  opcode == 6'h0D ? 6'h25 :
                  opcode == 6'h0E ? 6'h26 :
                  rtype           ? rtype_fncode : 6'h3F;
  assign hilo   = rtype && (rtype_fncode[5:2] == 4'h4 || rtype_fncode[5:2] == 4'h6);
  assign busy   = state_q != IDLE;
  assign stall  = valid_in && busy && hilo;
  assign go     = valid_in && rtype && state_q == IDLE;
  assign is_mul = rtype_fncode == 6'h19 || (SGN && rtype_fncode == 6'h18);
  assign is_div = rtype_fncode == 6'h1B || (SGN && rtype_fncode == 6'h1A);
  assign sgn_op = SGN && !rtype_fncode[0];
  // Signed ops run on magnitudes; the sign is restored in FIX.
  assign sa     = sgn_op && op_a[WIDTH-1];
  assign sb     = sgn_op && op_b[WIDTH-1];
  assign ma     = sa ? -op_a : op_a;
  assign mb     = sb ? -op_b : op_b;
  // With a zero divisor the raw dividend shifts straight into the remainder,
  // giving hi = op_a and lo = all ones without any correction.
  assign dz     = is_div && op_b == '0;
  assign hi     = hi_q;
  assign lo     = lo_q;
  always_comb begin
    msum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, {WIDTH{acc_q[0]}} & opnd_q};
    rsh    = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    ge     = rsh >= {1'b0, opnd_q};
    rnew   = ge ? WIDTH'(rsh - {1'b0, opnd_q}) : rsh[WIDTH-1:0];
    step_d = state_q == MUL ? {msum, acc_q[WIDTH-1:1]} : {rnew, acc_q[WIDTH-2:0], ge};
  end
`ifdef ALU_CTRL_SIGNED_MULDIV_EN
  always_comb
    fin_d = div_q ? {rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH],
                     qneg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]}
                  : (qneg_q ? -acc_q : acc_q);
`endif
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
`ifdef ALU_CTRL_SIGNED_MULDIV_EN
      sgn_q   <= 1'b0;
      div_q   <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
`endif
    end else
      case (state_q)
        IDLE:
          if (go) begin
            if (is_mul || is_div) begin
              state_q <= is_div ? DIV : MUL;
              cnt_q   <= CW'(WIDTH);
              acc_q   <= {{WIDTH{1'b0}}, dz ? op_a : ma};
              opnd_q  <= mb;
`ifdef ALU_CTRL_SIGNED_MULDIV_EN
              sgn_q   <= sgn_op;
              div_q   <= is_div;
              qneg_q  <= !dz && (sa ^ sb);
              rneg_q  <= !dz && sa;
`endif
            end else if (rtype_fncode == 6'h11) hi_q <= op_a;
            else if (rtype_fncode == 6'h13) lo_q <= op_a;
          end
        MUL, DIV: begin
          acc_q <= step_d;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
`ifdef ALU_CTRL_SIGNED_MULDIV_EN
            state_q <= sgn_q ? FIX : IDLE;
            if (!sgn_q) {hi_q, lo_q} <= step_d;
`else
            state_q <= IDLE;
            {hi_q, lo_q} <= step_d;
`endif
          end
        end
`ifdef ALU_CTRL_SIGNED_MULDIV_EN
        FIX: begin
          state_q <= IDLE;
          {hi_q, lo_q} <= fin_d;
        end
`endif
        default: state_q <= IDLE;
      endcase
endmodule

// File: tb/tb_alu_ctrl_seq.sv
// tb_alu_ctrl_seq: self-checking bench for alu_ctrl_seq (WIDTH=32) against an arithmetic reference model.
module tb_alu_ctrl_seq;
`ifdef ALU_CTRL_SIGNED_MULDIV_EN
  localparam bit SGN = 1'b1;
`else
  localparam bit SGN = 1'b0;
`endif
  localparam logic [31:0] ONES = 32'hFFFF_FFFF;
  logic        clk = 1'b0, reset = 1'b1, valid_in = 1'b0;
  logic [5:0]  opcode = 6'h00, rtype_fncode = 6'h00, fncode;
  logic [31:0] op_a = '0, op_b = '0, hi, lo;
  logic        stall, busy;
  logic [31:0] mdl_hi = '0, mdl_lo = '0;
  int          n_cmp = 0, n_err = 0;

  alu_ctrl_seq #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .opcode(opcode), .rtype_fncode(rtype_fncode),
    .op_a(op_a), .op_b(op_b), .fncode(fncode), .stall(stall), .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed running expected done");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [5:0] op, input logic [5:0] f,
                       input logic [31:0] a, input logic [31:0] b);
    valid_in = v; opcode = op; rtype_fncode = f; op_a = a; op_b = b;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Reference: HI/LO effect of one instruction from plain arithmetic; returns cycles busy stays high.
  function automatic int model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] r;
    case (f)
      6'h11: begin mdl_hi = a; return 0; end
      6'h13: begin mdl_lo = a; return 0; end
      6'h19: r = {32'h0, a} * {32'h0, b};
      6'h1B: r = (b == 0) ? {a, ONES} : {a % b, a / b};
      6'h18: if (!SGN) return 0; else r = 64'(longint'($signed(a)) * longint'($signed(b)));
      6'h1A:
        if (!SGN) return 0;
        else if (b == 0) r = {a, ONES};
        else if (a == 32'h8000_0000 && b == ONES) r = {32'h0, 32'h8000_0000};
        else r = {32'($signed(a) % $signed(b)), 32'($signed(a) / $signed(b))};
      default: return 0;
    endcase
    {mdl_hi, mdl_lo} = r;
    return (SGN && !f[0]) ? 33 : 32;
  endfunction

  task automatic run_op(input string tag, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    int exp_n, n;
    exp_n = model(f, a, b);
    drive(1'b1, 6'h00, f, a, b);
    tick();
    valid_in = 1'b0;
    n = 0;
    while (busy && n < 100) begin n++; tick(); end
    chk({tag, "_cycles"}, 64'(n), 64'(exp_n));
    chk({tag, "_hi"}, 64'(hi), 64'(mdl_hi));
    chk({tag, "_lo"}, 64'(lo), 64'(mdl_lo));
  endtask

  initial begin
    logic [5:0]  dec_op [8] = '{6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h00, 6'h23};
    logic [5:0]  dec_ex [8] = '{6'h21, 6'h2A, 6'h2B, 6'h24, 6'h25, 6'h26, 6'h00, 6'h3F};
    logic [5:0]  rnd_f  [6] = '{6'h19, 6'h1B, 6'h18, 6'h1A, 6'h11, 6'h13};
    logic [5:0]  rf, f;
    logic [31:0] old_hi, ra, rb;
    int          n, exp_n;

    // reset state
    #12;
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_hi", 64'(hi), 64'(0));
    chk("rst_lo", 64'(lo), 64'(0));
    @(negedge clk) reset = 1'b0;
    tick();
    chk("idle_stall", 64'(stall), 64'(0));

    // decode sweep (valid_in irrelevant)
    for (int i = 0; i < 8; i++) begin
      rf = 6'($urandom);
      drive(1'(i % 2), dec_op[i], rf, '0, '0);
      #1;
      chk($sformatf("dec_%02h", dec_op[i]), 64'(fncode), 64'(dec_op[i] == 6'h00 ? rf : dec_ex[i]));
    end
    drive(1'b0, 6'h00, 6'h00, '0, '0);
    tick();

    run_op("multu_max", 6'h19, ONES, ONES);
    chk("multu_max_hi_const", 64'(hi), 64'(32'hFFFF_FFFE));
    chk("multu_max_lo_const", 64'(lo), 64'(32'h0000_0001));

    // DIVU 5/0 with MFLO arriving at start+3
    exp_n = model(6'h1B, 32'd5, 32'd0);
    drive(1'b1, 6'h00, 6'h1B, 32'd5, 32'd0);
    tick();
    valid_in = 1'b0;
    tick();
    tick();
    drive(1'b1, 6'h00, 6'h12, '0, '0);
    #1;
    n = 3;
    while (busy && n < 100) begin
      chk("mflo_stall_busy", 64'(stall), 64'(1));
      tick();
      n++;
    end
    chk("divu0_cycles", 64'(n - 1), 64'(exp_n));
    chk("mflo_stall_fall", 64'(stall), 64'(0));
    chk("divu0_lo", 64'(lo), 64'(mdl_lo));
    chk("divu0_hi", 64'(hi), 64'(32'd5));
    valid_in = 1'b0;
    tick();

    // async reset in the middle of a MULTU
    drive(1'b1, 6'h00, 6'h19, 32'hDEAD_BEEF, 32'h1234_5678);
    tick();
    valid_in = 1'b0;
    repeat (9) tick();
    chk("mid_busy", 64'(busy), 64'(1));
    reset = 1'b1;
    #1;
    mdl_hi = '0; mdl_lo = '0;
    chk("mid_rst_busy", 64'(busy), 64'(0));
    chk("mid_rst_hi", 64'(hi), 64'(0));
    chk("mid_rst_lo", 64'(lo), 64'(0));
    @(negedge clk) reset = 1'b0;
    tick();
    run_op("multu_3x4", 6'h19, 32'd3, 32'd4);
    chk("multu_3x4_lo_const", 64'(lo), 64'(12));

    // MTHI idle, then MTHI and ADDIU while busy
    run_op("mthi_idle", 6'h11, 32'hA5A5_A5A5, '0);
    old_hi = mdl_hi;
    exp_n = model(6'h19, 32'h8765_4321, 32'hFEDC_BA98);
    drive(1'b1, 6'h00, 6'h19, 32'h8765_4321, 32'hFEDC_BA98);
    tick();
    drive(1'b1, 6'h09, 6'h11, '0, '0);
    #1;
    chk("addiu_busy_stall", 64'(stall), 64'(0));
    chk("addiu_busy_fn", 64'(fncode), 64'(6'h21));
    drive(1'b1, 6'h00, 6'h11, 32'hA5A5_A5A5, '0);
    #1;
    n = 0;
    while (busy && n < 100) begin
      chk("mthi_busy_stall", 64'(stall), 64'(1));
      chk("mthi_busy_hold", 64'(hi), 64'(old_hi));
      tick();
      n++;
    end
    chk("mthi_busy_cycles", 64'(n), 64'(exp_n));
    chk("mthi_fall_stall", 64'(stall), 64'(0));
    chk("mthi_fall_hi", 64'(hi), 64'(mdl_hi));
    tick();
    valid_in = 1'b0;
    void'(model(6'h11, 32'hA5A5_A5A5, '0));
    chk("mthi_late_hi", 64'(hi), 64'(mdl_hi));

    // signed ops (or their absence)
    run_op("div_m7_2", 6'h1A, 32'hFFFF_FFF9, 32'd2);
    run_op("div_ovf", 6'h1A, 32'h8000_0000, ONES);
    run_op("div_s0", 6'h1A, 32'hFFFF_FF00, 32'd0);
    run_op("mult_neg", 6'h18, 32'hFFFF_FFFD, 32'd7);

    // randomized mix
    for (int i = 0; i < 24; i++) begin
      f  = rnd_f[$urandom_range(0, 5)];
      ra = $urandom;
      case ($urandom_range(0, 3))
        0: rb = 32'($urandom_range(0, 7));
        1: rb = 32'h0;
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) ra = 32'h8000_0000;
      run_op($sformatf("rnd%0d_f%02h", i, f), f, ra, rb);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
